countdown_ctrl: RTL
===================

# countdown_ctrl

Sequencing controller for the 6-bit countdown datapath. It owns the down-counter register and a clock prescaler, and steps the count once per prescaled tick. It exposes load, start and pause controls plus expiry status. Its `count` output feeds the existing `sevenseg` display decoders, so the count now advances on the system clock instead of an external button edge.

## Interface
Parameters:
- `WIDTH`, 6: count width in bits.
- `PRESCALE`, 50_000_000: clock cycles per decrement tick. Must be ≥ 2.
- `AUTO_RELOAD`, 0: 1 = reload and keep running on expiry; 0 = stop on expiry.

Ports:
- `clk` input 1: single system clock. All state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `load` input 1: synchronous pulse. Loads `load_value`.
- `load_value` input WIDTH: value captured on `load`.
- `start` input 1: synchronous pulse. Starts or resumes the countdown.
- `pause` input 1: synchronous pulse. Freezes the countdown.
- `count` output WIDTH: current count.
- `state` output 2: FSM state, encoded IDLE=0, RUN=1, PAUSED=2, DONE=3.
- `running` output 1: high while in RUN.
- `done` output 1: high while in DONE.
- `expired` output 1: one-cycle pulse on each expiry.

## Operation
- Inputs are synchronous and sampled every clock. A level held high acts as repeated pulses; all commands are idempotent.
- Command priority, identical in every state: `load` > `pause` > `start`.
- Internal registers:
  - `count`.
  - `reload` (WIDTH): last loaded value.
  - `presc`: width $clog2(PRESCALE), runs 0..PRESCALE-1.
- `load` in any state: `count`←`load_value`, `reload`←`load_value`, `presc`←0, state→IDLE.
- IDLE:
  - `start` with `count`≠0 → RUN, `presc`←0.
  - `start` with `count`=0 is ignored.
- RUN:
  - `presc` increments each cycle.
  - When `presc`=PRESCALE-1 (tick): `presc`←0 and `count`←`count`-1, computed modulo 2^WIDTH.
  - Tick with `count`=1:
    - AUTO_RELOAD=0: `count`←0, state→DONE, `expired` pulses.
    - AUTO_RELOAD=1: `count`←`reload`, stay in RUN, `expired` pulses.
    - If `reload`=0, go to DONE regardless of AUTO_RELOAD.
  - `pause` → PAUSED. `presc` and `count` hold; no tick is taken in that cycle.
- PAUSED:
  - `start` → RUN, resuming from the held `presc` value (partial tick preserved).
  - `pause` is ignored.
- DONE:
  - `start` → `count`←`reload`, `presc`←0, RUN. Ignored if `reload`=0.
  - `pause` is ignored.
- `count` never underflows through 0 in RUN. The wrap arithmetic applies only to the internal subtract.

## Timing
- Reset (asynchronous, immediate on `rst_n` low): `count`=all ones (63), `reload`=all ones, `presc`=0, state=IDLE, `running`=0, `done`=0, `expired`=0.
- Reset has priority over every input. Release is synchronous to the next clock.
- All outputs are registered or are direct decodes of registered state. No combinational path from inputs to outputs.
- Decrement latency:
  - First decrement lands exactly PRESCALE cycles after the `start` edge.
  - Subsequent decrements follow every PRESCALE cycles.
- `expired` is high in the single cycle where `count` first shows 0 (or the reloaded value). It coincides with `done` rising when AUTO_RELOAD=0.
- Tick and `pause` in the same cycle: `pause` wins and the tick is deferred. On resume, the tick fires 1 cycle after the `start` edge.
- Tick and `load` in the same cycle: `load` wins and no `expired` pulse is generated.

## Structure
- Package `countdown_pkg`:
  - `state_t` enum (IDLE, RUN, PAUSED, DONE), 2-bit.
  - Constant `COUNT_RESET` = all ones.
- One sub-module, `tick_gen`: the prescaler. Ports are `clk`, `rst_n`, `clear`, `enable`, `tick`; parameter `PRESCALE`.
- FSM and count register stay in `countdown_ctrl`.
- The decrement reuses `full_substractor_n_bits` (`#(WIDTH)`) with subtrahend 1.
- Display stays external via two `sevenseg` instances on `count`.

## Test plan
All scenarios use PRESCALE=4 unless stated.

1. Assert `rst_n`=0 mid-cycle with no clock edge → immediately `count`=63, state=IDLE, `running`=`done`=`expired`=0.
2. `load_value`=5, pulse `load`, then pulse `start` → `count` reaches 4, 3, 2, 1, 0 at 4, 8, 12, 16, 20 cycles after `start`. At cycle 20: `expired`=1 for one cycle, `done`=1, state=DONE. `count` then holds at 0.
3. Load 5, start, pulse `pause` 6 cycles later → `count`=4 holds for 100 cycles. Pulse `start` → `count`=3 exactly 2 cycles later.
4. AUTO_RELOAD=1, load 3, start → at cycle 12: `expired` pulses, `count`=3, state stays RUN. Second `expired` pulse at cycle 24.
5. In RUN with `count`=4, pulse `load`=9 together with `start` → `count`=9, state=IDLE, `presc`=0, no decrement for 20 cycles. `start` with `count`=0 in IDLE → state stays IDLE.
6. Pulse `pause` in the same cycle as a tick with `count`=2 → `count` stays 2, state=PAUSED. On resume, `count`=1 one cycle after the `start` edge.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown controller and its prescaler.
package countdown_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Wide enough for any practical count width; users take the low WIDTH bits.
   localparam logic [63:0] COUNT_RESET = '1;

endpackage

// File: rtl/full_substractor_n_bits.sv
// Ripple-borrow subtractor: diff = a - b - bin, with borrow out of the MSB.
module full_substractor_n_bits #(
   parameter int WIDTH = 6
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   logic [WIDTH:0] borrow;

   always_comb begin
      borrow[0] = bin;
      for (int i = 0; i < WIDTH; i++) begin
         diff[i]       = a[i] ^ b[i] ^ borrow[i];
         borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
      end
      bout = borrow[WIDTH];
   end

endmodule

// File: rtl/tick_gen.sv
// Clock prescaler: counts enabled cycles 0..PRESCALE-1 and flags the last one as a tick.
module tick_gen #(
   parameter int PRESCALE = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int PW = $clog2(PRESCALE);

   logic [PW-1:0] presc;

   assign tick = enable && (presc == PW'(PRESCALE - 1));

   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (clear) begin
         presc <= '0;
      end else if (enable) begin
         presc <= tick ? '0 : presc + PW'(1);
      end
   end

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown sequencer: owns the count/reload registers and the IDLE/RUN/PAUSED/DONE FSM,
// stepping the count once per prescaled tick.
module countdown_ctrl
   import countdown_pkg::*;
#(
   parameter int WIDTH       = 6,
   parameter int PRESCALE    = 50_000_000,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             pause,
   output logic [WIDTH-1:0] count,
   output logic [1:0]       state,
   output logic             running,
   output logic             done,
   output logic             expired
);

   state_t           state_q, state_nxt;
   logic [WIDTH-1:0] count_q, count_nxt;
   logic [WIDTH-1:0] reload_q, reload_nxt;
   logic             expired_q, expired_nxt;
   logic             presc_clear, presc_enable, tick;
   logic [WIDTH-1:0] count_dec;
   logic             dec_borrow, is_last, go;

   full_substractor_n_bits #(.WIDTH(WIDTH)) u_dec (
      .a    (count_q),
      .b    (WIDTH'(1)),
      .bin  (1'b0),
      .diff (count_dec),
      .bout (dec_borrow)
   );

   assign is_last = (count_dec == '0) && !dec_borrow;

   // Pause and load both freeze the prescaler, so a coincident tick is never taken.
   assign presc_enable = (state_q == RUN) && !load && !pause;

   tick_gen #(.PRESCALE(PRESCALE)) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (presc_clear),
      .enable (presc_enable),
      .tick   (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= COUNT_RESET[WIDTH-1:0];
         reload_q  <= COUNT_RESET[WIDTH-1:0];
         expired_q <= 1'b0;
      end else begin
         count_q   <= count_nxt;
         reload_q  <= reload_nxt;
         expired_q <= expired_nxt;
      end
   end

   // Strict priority load > pause > start: a pause always masks a start.
   assign go = start && !pause;

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_nxt   = state_q;
      count_nxt   = count_q;
      reload_nxt  = reload_q;
      expired_nxt = 1'b0;
      presc_clear = 1'b0;
      if (load) begin
         state_nxt   = IDLE;
         count_nxt   = load_value;
         reload_nxt  = load_value;
         presc_clear = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (go && count_q != '0) begin
                  state_nxt   = RUN;
                  presc_clear = 1'b1;
               end
            end
            RUN: begin
               if (pause) begin
                  state_nxt = PAUSED;
               end else if (tick) begin
                  if (!is_last) begin
                     count_nxt = count_dec;
                  end else begin
                     expired_nxt = 1'b1;
                     if (AUTO_RELOAD && reload_q != '0) begin
                        count_nxt = reload_q;
                     end else begin
                        count_nxt = count_dec;
                        state_nxt = DONE;
                     end
                  end
               end
            end
            PAUSED: begin
               if (go) state_nxt = RUN;
            end
            DONE: begin
               if (go && reload_q != '0) begin
                  state_nxt   = RUN;
                  count_nxt   = reload_q;
                  presc_clear = 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      state   = state_q;
      running = (state_q == RUN);
      done    = (state_q == DONE);
   end

   assign count   = count_q;
   assign expired = expired_q;

endmodule
